// File: rtl/tbird_lights_monitor.sv
// -----------------------------------------------------------------------------
// tbird_lights_monitor
//   Watches the lamp patterns produced by a Thunderbird-style tail-light
//   sequencer, tracks which sequence step it is in, flags protocol errors
//   (illegal patterns or illegal step-to-step transitions) and counts
//   completed left, right and hazard sequences.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, highest priority
//   l_lights   in   [2:0] left lamp pattern
//   r_lights   in   [2:0] right lamp pattern
//   err_clr    in   clears seq_err / err_code (a coincident error wins)
//   cnt_clr    in   zeroes all counters (wins over a coincident increment)
//   dir        out  [1:0] 00 none, 01 left, 10 right, 11 hazard
//   step       out  [1:0] step 1..3 within a left/right sequence, else 0
//   seq_err    out  sticky protocol-error flag
//   err_code   out  [1:0] first error cause: 01 illegal pattern, 10 illegal transition
//   left_cnt   out  [CNT_W-1:0] completed left sequences (L2->L3), saturating
//   right_cnt  out  [CNT_W-1:0] completed right sequences (R2->R3), saturating
//   haz_cnt    out  [CNT_W-1:0] error-free entries into hazard, saturating
// -----------------------------------------------------------------------------
module tbird_lights_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       l_lights,
  input  logic [2:0]       r_lights,
  input  logic             err_clr,
  input  logic             cnt_clr,
  output logic [1:0]       dir,
  output logic [1:0]       step,
  output logic             seq_err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] left_cnt,
  output logic [CNT_W-1:0] right_cnt,
  output logic [CNT_W-1:0] haz_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_LR3, S_UNSYNC
  } state_t;

  localparam logic [1:0]       ERR_NONE  = 2'b00;
  localparam logic [1:0]       ERR_PAT   = 2'b01;
  localparam logic [1:0]       ERR_TRANS = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state_q, state_d;
  state_t     pat_state;
  logic       pat_legal;
  logic       trans_ok;
  logic       pat_err, trans_err, any_err;
  logic [1:0] err_cause;
  logic [1:0] dir_d, step_d;
  logic       inc_left, inc_right, inc_haz;

  // Pattern decode, transition legality, next state and registered-output values.
  // NOTE: every signal gets a default at the top of the block so no path
  // through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    pat_legal = 1'b1;
    pat_state = S_IDLE;
    trans_ok  = 1'b0;
    dir_d     = 2'b00;
    step_d    = 2'b00;

    case ({l_lights, r_lights})
      6'b000_000: pat_state = S_IDLE;
      6'b001_000: pat_state = S_L1;
      6'b010_000: pat_state = S_L2;
      6'b011_000: pat_state = S_L3;
      6'b000_001: pat_state = S_R1;
      6'b000_010: pat_state = S_R2;
      6'b000_011: pat_state = S_R3;
      6'b111_111: pat_state = S_LR3;
      default:    pat_legal = 1'b0;
    endcase

    case (state_q)
      S_IDLE:   trans_ok = pat_state inside {S_IDLE, S_L1, S_R1, S_LR3};
      S_L1:     trans_ok = pat_state inside {S_L2, S_LR3};
      S_L2:     trans_ok = pat_state inside {S_L3, S_LR3};
      S_L3:     trans_ok = pat_state inside {S_L1, S_LR3};
      S_R1:     trans_ok = pat_state inside {S_R2, S_LR3};
      S_R2:     trans_ok = pat_state inside {S_R3, S_LR3};
      S_R3:     trans_ok = pat_state inside {S_R1, S_LR3};
      S_LR3:    trans_ok = (pat_state == S_IDLE);
      S_UNSYNC: trans_ok = 1'b1;   // any legal pattern resynchronises
      default:  trans_ok = 1'b0;
    endcase

    pat_err   = !pat_legal;
    trans_err = pat_legal && !trans_ok;
    any_err   = pat_err || trans_err;
    err_cause = pat_err ? ERR_PAT : ERR_TRANS;
    state_d   = pat_legal ? pat_state : S_UNSYNC;

    case (state_d)
      S_L1:    begin dir_d = 2'b01; step_d = 2'd1; end
      S_L2:    begin dir_d = 2'b01; step_d = 2'd2; end
      S_L3:    begin dir_d = 2'b01; step_d = 2'd3; end
      S_R1:    begin dir_d = 2'b10; step_d = 2'd1; end
      S_R2:    begin dir_d = 2'b10; step_d = 2'd2; end
      S_R3:    begin dir_d = 2'b10; step_d = 2'd3; end
      S_LR3:   dir_d = 2'b11;
      default: ;
    endcase

    // L2->L3 and R2->R3 are always legal, so no error term is needed there.
    inc_left  = pat_legal && (state_q == S_L2) && (pat_state == S_L3);
    inc_right = pat_legal && (state_q == S_R2) && (pat_state == S_R3);
    inc_haz   = pat_legal && (pat_state == S_LR3) && !trans_err;
  end

  // Tracker state and decoded outputs. Clear strobes never touch the tracker.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir     <= 2'b00;
      step    <= 2'b00;
    end else begin
      state_q <= state_d;
      dir     <= dir_d;
      step    <= step_d;
    end
  end

  // Error flag and first-cause code; a new error outranks err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_err  <= 1'b0;
      err_code <= ERR_NONE;
    end else if (any_err) begin
      seq_err <= 1'b1;
      if (err_clr || err_code == ERR_NONE) err_code <= err_cause;
    end else if (err_clr) begin
      seq_err  <= 1'b0;
      err_code <= ERR_NONE;
    end
  end

  // Saturating counters; cnt_clr outranks a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      left_cnt  <= '0;
      right_cnt <= '0;
      haz_cnt   <= '0;
    end else begin
      if (inc_left  && left_cnt  != CNT_MAX) left_cnt  <= left_cnt  + 1'b1;
      if (inc_right && right_cnt != CNT_MAX) right_cnt <= right_cnt + 1'b1;
      if (inc_haz   && haz_cnt   != CNT_MAX) haz_cnt   <= haz_cnt   + 1'b1;
    end
  end

endmodule

// File: tb/tb_tbird_lights_monitor.sv
// -----------------------------------------------------------------------------
// tb_tbird_lights_monitor
//   Directed bench for tbird_lights_monitor. Two instances share all inputs:
//   dut (CNT_W=8) and dut2 (CNT_W=2, used for the saturation scenario).
//   Inputs change on the falling edge; outputs are sampled #1 after the
//   rising edge that captured them.
// -----------------------------------------------------------------------------
module tb_tbird_lights_monitor;

  localparam logic [5:0] P_IDLE = 6'b000_000;
  localparam logic [5:0] P_L1   = 6'b001_000;
  localparam logic [5:0] P_L2   = 6'b010_000;
  localparam logic [5:0] P_L3   = 6'b011_000;
  localparam logic [5:0] P_R1   = 6'b000_001;
  localparam logic [5:0] P_R2   = 6'b000_010;
  localparam logic [5:0] P_R3   = 6'b000_011;
  localparam logic [5:0] P_LR3  = 6'b111_111;
  localparam logic [5:0] P_BAD  = 6'b101_000;
  localparam logic [5:0] P_BAD2 = 6'b001_001;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] l_lights, r_lights;
  logic       err_clr, cnt_clr;
  logic [1:0] dir, step, err_code;
  logic       seq_err;
  logic [7:0] left_cnt, right_cnt, haz_cnt;
  logic [1:0] dir2, step2, err_code2;
  logic       seq_err2;
  logic [1:0] left_cnt2, right_cnt2, haz_cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tbird_lights_monitor #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .l_lights(l_lights), .r_lights(r_lights),
    .err_clr(err_clr), .cnt_clr(cnt_clr), .dir(dir), .step(step),
    .seq_err(seq_err), .err_code(err_code), .left_cnt(left_cnt),
    .right_cnt(right_cnt), .haz_cnt(haz_cnt)
  );

  tbird_lights_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .l_lights(l_lights), .r_lights(r_lights),
    .err_clr(err_clr), .cnt_clr(cnt_clr), .dir(dir2), .step(step2),
    .seq_err(seq_err2), .err_code(err_code2), .left_cnt(left_cnt2),
    .right_cnt(right_cnt2), .haz_cnt(haz_cnt2)
  );

  // One clock: present inputs on the falling edge, return #1 after the
  // rising edge that samples them.
  task automatic cycle(input logic [5:0] pat, input logic ec = 1'b0,
                       input logic cc = 1'b0, input logic rs = 1'b0);
    @(negedge clk);
    {l_lights, r_lights} = pat;
    err_clr = ec;
    cnt_clr = cc;
    rst     = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(P_IDLE, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    // Garbage inputs alongside rst: reset must still win.
    cycle(P_BAD, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({dir, step, seq_err, err_code} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: dir=%b step=%0d seq_err=%b err_code=%b, required all zero",
               dir, step, seq_err, err_code);
    end
    checks++;
    if ({left_cnt, right_cnt, haz_cnt} !== 24'b0) begin
      failures++;
      $display("FAIL reset_counters: left=%0d right=%0d haz=%0d, required 0/0/0",
               left_cnt, right_cnt, haz_cnt);
    end
  endtask

  task automatic test_left_sequence();
    logic [5:0] pats [7] = '{P_IDLE, P_L1, P_L2, P_L3, P_L1, P_L2, P_L3};
    logic [1:0] edir [7] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [1:0] estp [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(pats[i]);
      checks++;
      if (dir !== edir[i] || step !== estp[i]) begin
        failures++;
        $display("FAIL left_seq[%0d]: dir=%b step=%0d, required dir=%b step=%0d",
                 i, dir, step, edir[i], estp[i]);
      end
    end
    checks++;
    if (left_cnt !== 8'd2 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL left_seq_end: left_cnt=%0d seq_err=%b, required 2/0", left_cnt, seq_err);
    end
  endtask

  task automatic test_right_hazard();
    logic [5:0] pats [5] = '{P_IDLE, P_R1, P_R2, P_LR3, P_IDLE};
    logic [1:0] edir [5] = '{2'b00, 2'b10, 2'b10, 2'b11, 2'b00};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(pats[i]);
      checks++;
      if (dir !== edir[i]) begin
        failures++;
        $display("FAIL right_haz[%0d]: dir=%b, required %b", i, dir, edir[i]);
      end
    end
    checks++;
    if (haz_cnt !== 8'd1 || right_cnt !== 8'd0 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL right_haz_end: haz=%0d right=%0d seq_err=%b, required 1/0/0",
               haz_cnt, right_cnt, seq_err);
    end
    // Full right sequence through R3 bumps right_cnt.
    cycle(P_R1); cycle(P_R2); cycle(P_R3);
    checks++;
    if (right_cnt !== 8'd1 || step !== 2'd3 || dir !== 2'b10) begin
      failures++;
      $display("FAIL right_cnt: right=%0d dir=%b step=%0d, required 1/10/3", right_cnt, dir, step);
    end
  endtask

  task automatic test_pattern_error();
    do_reset();
    cycle(P_IDLE);
    cycle(P_BAD);
    checks++;
    if (seq_err !== 1'b1 || err_code !== 2'b01 || dir !== 2'b00) begin
      failures++;
      $display("FAIL pat_err: seq_err=%b err_code=%b dir=%b, required 1/01/00", seq_err, err_code, dir);
    end
    // Illegal again while UNSYNC: stays UNSYNC, code unchanged.
    cycle(P_BAD2);
    checks++;
    if (dir !== 2'b00 || step !== 2'd0 || err_code !== 2'b01) begin
      failures++;
      $display("FAIL unsync_hold: dir=%b step=%0d err_code=%b, required 00/0/01", dir, step, err_code);
    end
    cycle(P_R1);
    checks++;
    if (dir !== 2'b10 || step !== 2'd1 || err_code !== 2'b01 || seq_err !== 1'b1) begin
      failures++;
      $display("FAIL resync: dir=%b step=%0d err_code=%b seq_err=%b, required 10/1/01/1",
               dir, step, err_code, seq_err);
    end
    // R1->L1 is a transition error; first cause (01) must persist.
    cycle(P_L1);
    checks++;
    if (err_code !== 2'b01 || dir !== 2'b01 || step !== 2'd1) begin
      failures++;
      $display("FAIL first_err_wins: err_code=%b dir=%b step=%0d, required 01/01/1", err_code, dir, step);
    end
  endtask

  task automatic test_transition_error();
    do_reset();
    cycle(P_LR3);
    cycle(P_LR3);
    checks++;
    if (err_code !== 2'b10 || seq_err !== 1'b1 || haz_cnt !== 8'd1 || dir !== 2'b11) begin
      failures++;
      $display("FAIL lr3_hold: err_code=%b seq_err=%b haz=%0d dir=%b, required 10/1/1/11",
               err_code, seq_err, haz_cnt, dir);
    end
    // err_clr together with an illegal pattern: new cause loads.
    cycle(P_BAD, 1'b1);
    checks++;
    if (seq_err !== 1'b1 || err_code !== 2'b01) begin
      failures++;
      $display("FAIL clr_vs_pat_err: seq_err=%b err_code=%b, required 1/01", seq_err, err_code);
    end
    cycle(P_IDLE);
    cycle(P_IDLE, 1'b1);
    checks++;
    if (seq_err !== 1'b0 || err_code !== 2'b00) begin
      failures++;
      $display("FAIL err_clr: seq_err=%b err_code=%b, required 0/00", seq_err, err_code);
    end
    cycle(P_L1);
    cycle(P_L3, 1'b1);
    checks++;
    if (seq_err !== 1'b1 || err_code !== 2'b10 || step !== 2'd3) begin
      failures++;
      $display("FAIL clr_vs_trans_err: seq_err=%b err_code=%b step=%0d, required 1/10/3",
               seq_err, err_code, step);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    cycle(P_IDLE);
    for (int n = 0; n < 5; n++) begin
      cycle(P_L1); cycle(P_L2); cycle(P_L3);
    end
    checks++;
    if (left_cnt2 !== 2'd3 || left_cnt !== 8'd5) begin
      failures++;
      $display("FAIL saturate: left_cnt(W2)=%0d left_cnt(W8)=%0d, required 3/5", left_cnt2, left_cnt);
    end
    // cnt_clr during L1 must not disturb the tracker.
    cycle(P_L1, 1'b0, 1'b1);
    cycle(P_L2);
    checks++;
    if (step !== 2'd2 || seq_err !== 1'b0 || left_cnt !== 8'd0) begin
      failures++;
      $display("FAIL cnt_clr_tracker: step=%0d seq_err=%b left=%0d, required 2/0/0", step, seq_err, left_cnt);
    end
    cycle(P_L3, 1'b0, 1'b1);
    checks++;
    if (left_cnt2 !== 2'd0 || left_cnt !== 8'd0 || step !== 2'd3) begin
      failures++;
      $display("FAIL clr_vs_inc: left(W2)=%0d left(W8)=%0d step=%0d, required 0/0/3",
               left_cnt2, left_cnt, step);
    end
  endtask

  task automatic test_reset_mid_sequence();
    do_reset();
    cycle(P_L1); cycle(P_L2);
    cycle(P_L3);                       // left_cnt -> 1, so reset has something to clear
    cycle(P_L1); cycle(P_L2);
    cycle(P_LR3, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({dir, step, seq_err, err_code} !== 7'b0 || left_cnt !== 8'd0 || haz_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid: dir=%b step=%0d seq_err=%b err_code=%b left=%0d haz=%0d, required zeros",
               dir, step, seq_err, err_code, left_cnt, haz_cnt);
    end
    cycle(P_L1);
    checks++;
    if (dir !== 2'b01 || step !== 2'd1 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_l1: dir=%b step=%0d seq_err=%b, required 01/1/0", dir, step, seq_err);
    end
    cycle(P_L2);
    do_reset();
    cycle(P_L3);
    checks++;
    if (seq_err !== 1'b1 || err_code !== 2'b10) begin
      failures++;
      $display("FAIL after_reset_l3: seq_err=%b err_code=%b, required 1/10", seq_err, err_code);
    end
  endtask

  initial begin
    rst = 1'b1;
    {l_lights, r_lights} = P_IDLE;
    err_clr = 1'b0;
    cnt_clr = 1'b0;
    test_reset();
    test_left_sequence();
    test_right_hazard();
    test_pattern_error();
    test_transition_error();
    test_saturation();
    test_reset_mid_sequence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
